// File: rtl/stack_sequencer.sv
// Stack push/pop sequencer: walks push (low->high) then pop (high->low) masks,
// one word-sized bus transaction per set slot, tracking SP modulo 2^ADDR_W.

module stack_seq_pick #(
  parameter int W          = 16,
  parameter int SW         = 4,
  parameter bit HIGH_FIRST = 1'b0
) (
  input  logic [W-1:0]  bits,
  output logic [SW-1:0] idx,
  output logic [W-1:0]  onehot
);
  // Last match in scan order wins, so the scan direction selects the priority end.
  always_comb begin
    idx = '0;
    for (int i = 0; i < W; i++) begin
      if (HIGH_FIRST) begin
        if (bits[i]) idx = SW'(i);
      end else begin
        if (bits[W-1-i]) idx = SW'(W-1-i);
      end
    end
    onehot = (bits == '0) ? '0 : (W'(1) << idx);
  end
endmodule

module stack_sequencer #(
  parameter int              MASK_W       = 16,
  parameter int              ADDR_W       = 16,
  parameter int              WORD_BYTES   = 2,
  parameter logic [MASK_W-1:0] DISCARD_MASK = MASK_W'('h20),
  localparam int             SLOT_W       = (MASK_W > 1) ? $clog2(MASK_W) : 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [MASK_W-1:0] push_mask,
  input  logic [MASK_W-1:0] pop_mask,
  input  logic [ADDR_W-1:0] sp_in,
  output logic              busy,
  output logic              done,
  output logic              bus_req,
  output logic              bus_write,
  output logic [ADDR_W-1:0] bus_addr,
  input  logic              bus_ack,
  output logic [SLOT_W-1:0] slot_idx,
  output logic              rd_valid,
  output logic [ADDR_W-1:0] sp_out,
  output logic              sp_wr
);
  localparam logic [ADDR_W-1:0] STEP = ADDR_W'(WORD_BYTES);

  typedef enum logic [1:0] {IDLE, PUSH, POP, FIN} state_t;

  state_t              state, state_n;
  logic [MASK_W-1:0]   rem_push, rem_push_n, rem_pop, rem_pop_n;
  logic [ADDR_W-1:0]   sp_cur, sp_n;
  logic [SLOT_W-1:0]   push_idx, pop_idx;
  logic [MASK_W-1:0]   push_oh, pop_oh;

  stack_seq_pick #(.W(MASK_W), .SW(SLOT_W), .HIGH_FIRST(1'b0)) u_pick_push (
    .bits(rem_push), .idx(push_idx), .onehot(push_oh)
  );
  stack_seq_pick #(.W(MASK_W), .SW(SLOT_W), .HIGH_FIRST(1'b1)) u_pick_pop (
    .bits(rem_pop), .idx(pop_idx), .onehot(pop_oh)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      rem_push <= '0;
      rem_pop  <= '0;
      sp_cur   <= '0;
    end else begin
      state    <= state_n;
      rem_push <= rem_push_n;
      rem_pop  <= rem_pop_n;
      sp_cur   <= sp_n;
    end
  end

  // Bus outputs decode only registered state, so they hold steady until acked.
  always_comb begin
    state_n    = state;
    rem_push_n = rem_push;
    rem_pop_n  = rem_pop;
    sp_n       = sp_cur;
    busy       = 1'b0;
    done       = 1'b0;
    bus_req    = 1'b0;
    bus_write  = 1'b0;
    bus_addr   = '0;
    slot_idx   = '0;
    rd_valid   = 1'b0;
    sp_out     = '0;
    case (state)
      IDLE: begin
        if (start) begin
          rem_push_n = push_mask;
          rem_pop_n  = pop_mask;
          sp_n       = sp_in;
          if (push_mask != '0)     state_n = PUSH;
          else if (pop_mask != '0) state_n = POP;
          else                     state_n = FIN;
        end
      end
      PUSH: begin
        busy      = 1'b1;
        bus_req   = 1'b1;
        bus_write = 1'b1;
        bus_addr  = sp_cur - STEP;
        slot_idx  = push_idx;
        if (bus_ack) begin
          sp_n       = sp_cur - STEP;
          rem_push_n = rem_push & ~push_oh;
          if (rem_push_n == '0) state_n = (rem_pop != '0) ? POP : FIN;
        end
      end
      POP: begin
        busy     = 1'b1;
        bus_req  = 1'b1;
        bus_addr = sp_cur;
        slot_idx = pop_idx;
        if (bus_ack) begin
          rd_valid  = ~DISCARD_MASK[pop_idx];
          sp_n      = sp_cur + STEP;
          rem_pop_n = rem_pop & ~pop_oh;
          if (rem_pop_n == '0) state_n = FIN;
        end
      end
      FIN: begin
        busy    = 1'b1;
        done    = 1'b1;
        sp_out  = sp_cur;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
    sp_wr = done;
  end
endmodule
